// File: rtl/downmix_filter_sched_if.sv
// Mixer-side bus of downmix_filter_sched: run enable and I/Q samples in, filtered I/Q and status out.
interface downmix_filter_sched_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] i_in;
    logic signed [DATA_WIDTH-1:0] q_in;
    logic signed [DATA_WIDTH-1:0] i_out;
    logic signed [DATA_WIDTH-1:0] q_out;
    logic                         out_valid;
    logic                         busy;
    logic                         overrun;

    modport master (output start, i_in, q_in, input i_out, q_out, out_valid, busy, overrun);
    modport slave  (input start, i_in, q_in, output i_out, q_out, out_valid, busy, overrun);
endinterface

// File: rtl/downmix_filter_sched.sv
// Shared serial-MAC low-pass scheduler for the downmixer I/Q paths, decimated to the demod rate.
// Define SCHED_SAT_EN to saturate the shifted tap sum instead of wrapping it.
module downmix_filter_sched #(
    parameter int TAPS         = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int SYS_CLK_FREQ = 6_400_000,
    parameter int MIXING_FREQ  = 320_000,
    parameter int DECIM        = 20,
    parameter int SHIFT        = 3
) (
    input logic                   clk,
    input logic                   rst,
    downmix_filter_sched_if.slave bus
);
    localparam int SAMPLE_DIV = SYS_CLK_FREQ / MIXING_FREQ;
    localparam int ACC_W      = DATA_WIDTH + $clog2(TAPS) + 1;
    localparam int CNT_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int DEC_W      = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {IDLE, MAC_I, MAC_Q, OUT} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         tick_q, tick_d;
    logic [TAP_W-1:0]             tap_idx_q, tap_idx_d;
    logic [DEC_W-1:0]             decim_q, decim_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] i_line_q [TAPS];
    logic signed [DATA_WIDTH-1:0] i_line_d [TAPS];
    logic signed [DATA_WIDTH-1:0] q_line_q [TAPS];
    logic signed [DATA_WIDTH-1:0] q_line_d [TAPS];
    logic signed [DATA_WIDTH-1:0] i_res_q, i_res_d;
    logic signed [DATA_WIDTH-1:0] q_res_q, q_res_d;
    logic signed [DATA_WIDTH-1:0] i_out_q, i_out_d;
    logic signed [DATA_WIDTH-1:0] q_out_q, q_out_d;
    logic                         out_valid_q, out_valid_d;
    logic                         busy_q, busy_d;
    logic                         overrun_q, overrun_d;
    logic signed [DATA_WIDTH-1:0] tap_sel;
    logic signed [ACC_W-1:0]      mac_sum;
    logic                         last_tap;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_WIDTH-1:0] x);
        return $signed({{(ACC_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x});
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] shifted;
        shifted = sum >>> SHIFT;
`ifdef SCHED_SAT_EN
        if (shifted > $signed({{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}}))
            return $signed({1'b0, {(DATA_WIDTH-1){1'b1}}});
        else if (shifted < $signed({{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}}))
            return $signed({1'b1, {(DATA_WIDTH-1){1'b0}}});
        else
            return shifted[DATA_WIDTH-1:0];
`else
        return shifted[DATA_WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        tick_d      = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        cnt_d       = tick_d ? '0 : cnt_q + 1'b1;
        state_d     = state_q;
        tap_idx_d   = tap_idx_q;
        decim_d     = decim_q;
        acc_d       = acc_q;
        i_line_d    = i_line_q;
        q_line_d    = q_line_q;
        i_res_d     = i_res_q;
        q_res_d     = q_res_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        tap_sel     = (state_q == MAC_Q) ? q_line_q[tap_idx_q] : i_line_q[tap_idx_q];
        mac_sum     = acc_q + sext(tap_sel);
        last_tap    = (tap_idx_q == TAP_W'(TAPS - 1));

        // A low start abandons the computation; delay lines and outputs keep their values
        if (!bus.start) begin
            state_d   = IDLE;
            tap_idx_d = '0;
            decim_d   = '0;
            acc_d     = '0;
            overrun_d = 1'b0;
        end else begin
            if (tick_q && state_q != IDLE)
                overrun_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (tick_q) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            i_line_d[k] = i_line_q[k-1];
                            q_line_d[k] = q_line_q[k-1];
                        end
                        i_line_d[0] = bus.i_in;
                        q_line_d[0] = bus.q_in;
                        acc_d       = '0;
                        tap_idx_d   = '0;
                        state_d     = MAC_I;
                    end
                end
                MAC_I, MAC_Q: begin
                    if (last_tap) begin
                        if (state_q == MAC_I) begin
                            i_res_d = reduce(mac_sum);
                            state_d = MAC_Q;
                        end else begin
                            q_res_d = reduce(mac_sum);
                            state_d = OUT;
                        end
                        acc_d     = '0;
                        tap_idx_d = '0;
                    end else begin
                        acc_d     = mac_sum;
                        tap_idx_d = tap_idx_q + 1'b1;
                    end
                end
                OUT: begin
                    if (decim_q == DEC_W'(DECIM - 1)) begin
                        i_out_d     = i_res_q;
                        q_out_d     = q_res_q;
                        out_valid_d = 1'b1;
                        decim_d     = '0;
                    end else begin
                        decim_d = decim_q + 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            tap_idx_q   <= '0;
            decim_q     <= '0;
            acc_q       <= '0;
            i_line_q    <= '{default: '0};
            q_line_q    <= '{default: '0};
            i_res_q     <= '0;
            q_res_q     <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            tap_idx_q   <= tap_idx_d;
            decim_q     <= decim_d;
            acc_q       <= acc_d;
            i_line_q    <= i_line_d;
            q_line_q    <= q_line_d;
            i_res_q     <= i_res_d;
            q_res_q     <= q_res_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.i_out     = i_out_q;
    assign bus.q_out     = q_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_downmix_filter_sched.sv
// Directed bench for downmix_filter_sched: default, DECIM=1, SHIFT=0 and TAPS=12 instances on one clock.
module tb_downmix_filter_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    downmix_filter_sched_if b_def ();
    downmix_filter_sched_if b_d1 ();
    downmix_filter_sched_if b_s0 ();
    downmix_filter_sched_if b_t12 ();

    downmix_filter_sched u_def (.clk(clk), .rst(rst), .bus(b_def.slave));
    downmix_filter_sched #(.DECIM(1)) u_d1 (.clk(clk), .rst(rst), .bus(b_d1.slave));
    downmix_filter_sched #(.SHIFT(0), .DECIM(1)) u_s0 (.clk(clk), .rst(rst), .bus(b_s0.slave));
    downmix_filter_sched #(.TAPS(12), .DECIM(1)) u_t12 (.clk(clk), .rst(rst), .bus(b_t12.slave));

    task automatic test_reset();
        rst = 1'b1;
        b_def.start = 0; b_def.i_in = 0; b_def.q_in = 0;
        b_d1.start  = 0; b_d1.i_in  = 0; b_d1.q_in  = 0;
        b_s0.start  = 0; b_s0.i_in  = 0; b_s0.q_in  = 0;
        b_t12.start = 0; b_t12.i_in = 0; b_t12.q_in = 0;
        #2 rst = 1'b0;
        #20;
        n_vec++; if (b_def.i_out !== 16'sd0) begin n_err++; $display("FAIL reset_i_out: got %0d expected 0", b_def.i_out); end
        n_vec++; if (b_def.q_out !== 16'sd0) begin n_err++; $display("FAIL reset_q_out: got %0d expected 0", b_def.q_out); end
        n_vec++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", b_def.out_valid); end
        n_vec++; if (b_def.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", b_def.busy); end
        n_vec++; if (b_t12.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", b_t12.overrun); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_steady();
        int pulses = 0, cyc = 0, last = 0, run = 0;
        logic prev_busy = 1'b0;
        b_def.i_in = 16'sd800; b_def.q_in = -16'sd800; b_def.start = 1'b1;
        while (pulses < 7 && cyc < 4000) begin
            @(negedge clk); cyc++;
            if (b_def.out_valid) begin
                pulses++;
                n_vec++; if (b_def.i_out !== 16'sd600) begin n_err++; $display("FAIL steady_i #%0d: got %0d expected 600", pulses, b_def.i_out); end
                n_vec++; if (b_def.q_out !== -16'sd600) begin n_err++; $display("FAIL steady_q #%0d: got %0d expected -600", pulses, b_def.q_out); end
                n_vec++; if (run !== 13 || b_def.busy !== 1'b0) begin n_err++; $display("FAIL steady_latency #%0d: busy run %0d busy %b expected 13 then 0", pulses, run, b_def.busy); end
                if (pulses > 1) begin
                    n_vec++; if (cyc - last !== 400) begin n_err++; $display("FAIL steady_interval #%0d: got %0d expected 400", pulses, cyc - last); end
                end
                last = cyc;
            end
            if (b_def.busy) run = prev_busy ? run + 1 : 1;
            prev_busy = b_def.busy;
        end
        n_vec++; if (pulses !== 7) begin n_err++; $display("FAIL steady_timeout: got %0d pulses expected 7", pulses); end
        @(negedge clk);
        n_vec++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL steady_pulse_width: got %b expected 0", b_def.out_valid); end
    endtask

    task automatic test_start_drop();
        int cyc = 0, rises = 0;
        logic prev_busy;
        prev_busy = b_def.busy;
        while (!(b_def.busy && !prev_busy) && cyc < 100) begin
            prev_busy = b_def.busy; @(negedge clk); cyc++;
        end
        repeat (9) @(negedge clk);
        b_def.start = 1'b0;
        @(negedge clk);
        n_vec++; if (b_def.busy !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b expected 0", b_def.busy); end
        n_vec++; if (b_def.out_valid !== 1'b0) begin n_err++; $display("FAIL drop_out_valid: got %b expected 0", b_def.out_valid); end
        n_vec++; if (b_def.i_out !== 16'sd600) begin n_err++; $display("FAIL drop_hold_i: got %0d expected 600", b_def.i_out); end
        repeat (30) @(negedge clk);
        b_def.start = 1'b1;
        cyc = 0; prev_busy = 1'b0;
        while (!b_def.out_valid && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (b_def.busy && !prev_busy) rises++;
            prev_busy = b_def.busy;
        end
        n_vec++; if (rises !== 20 || !b_def.out_valid) begin n_err++; $display("FAIL restart_decim: %0d computations (valid %b) expected 20", rises, b_def.out_valid); end
    endtask

    task automatic test_impulse();
        int pulses = 0, cyc = 0, last = 0;
        logic signed [15:0] exp_i;
        b_d1.i_in = 16'sd1000; b_d1.q_in = 16'sd0;
        @(negedge clk) b_d1.start = 1'b1;
        while (!b_d1.busy && cyc < 60) begin @(negedge clk); cyc++; end
        b_d1.i_in = 16'sd0;
        cyc = 0;
        while (pulses < 8 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (b_d1.out_valid) begin
                pulses++;
                exp_i = (pulses <= 6) ? 16'sd125 : 16'sd0;
                n_vec++; if (b_d1.i_out !== exp_i) begin n_err++; $display("FAIL impulse_i #%0d: got %0d expected %0d", pulses, b_d1.i_out, exp_i); end
                n_vec++; if (b_d1.q_out !== 16'sd0) begin n_err++; $display("FAIL impulse_q #%0d: got %0d expected 0", pulses, b_d1.q_out); end
                if (pulses > 1) begin
                    n_vec++; if (cyc - last !== 20) begin n_err++; $display("FAIL impulse_interval #%0d: got %0d expected 20", pulses, cyc - last); end
                end
                last = cyc;
            end
        end
        n_vec++; if (pulses !== 8) begin n_err++; $display("FAIL impulse_timeout: got %0d pulses expected 8", pulses); end
    endtask

    task automatic test_saturation();
        int pulses = 0, cyc = 0;
        logic signed [15:0] exp_i, exp_q;
`ifdef SCHED_SAT_EN
        exp_i = 16'sd32767; exp_q = -16'sd32768;
`else
        exp_i = -16'sd6; exp_q = 16'sd0;
`endif
        b_s0.i_in = 16'sd32767; b_s0.q_in = -16'sd32768; b_s0.start = 1'b1;
        while (pulses < 7 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (b_s0.out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    n_vec++; if (b_s0.i_out !== 16'sd32767) begin n_err++; $display("FAIL sat_first_i: got %0d expected 32767", b_s0.i_out); end
                    n_vec++; if (b_s0.q_out !== -16'sd32768) begin n_err++; $display("FAIL sat_first_q: got %0d expected -32768", b_s0.q_out); end
                end
            end
        end
        n_vec++; if (pulses !== 7) begin n_err++; $display("FAIL sat_timeout: got %0d pulses expected 7", pulses); end
        n_vec++; if (b_s0.i_out !== exp_i) begin n_err++; $display("FAIL sat_steady_i: got %0d expected %0d", b_s0.i_out, exp_i); end
        n_vec++; if (b_s0.q_out !== exp_q) begin n_err++; $display("FAIL sat_steady_q: got %0d expected %0d", b_s0.q_out, exp_q); end
    endtask

    task automatic test_overrun();
        int pulses = 0, cyc = 0, last = 0;
        n_vec++; if (b_t12.overrun !== 1'b0) begin n_err++; $display("FAIL overrun_initial: got %b expected 0", b_t12.overrun); end
        b_t12.i_in = 16'sd80; b_t12.q_in = 16'sd0; b_t12.start = 1'b1;
        while (pulses < 3 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (b_t12.out_valid) begin
                pulses++;
                n_vec++; if (b_t12.overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set #%0d: got %b expected 1", pulses, b_t12.overrun); end
                if (pulses > 1) begin
                    n_vec++; if (cyc - last !== 40) begin n_err++; $display("FAIL overrun_interval #%0d: got %0d expected 40", pulses, cyc - last); end
                end
                last = cyc;
            end
        end
        n_vec++; if (pulses !== 3) begin n_err++; $display("FAIL overrun_timeout: got %0d pulses expected 3", pulses); end
        b_t12.start = 1'b0;
        @(negedge clk);
        b_t12.start = 1'b1;
        n_vec++; if (b_t12.overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b expected 0", b_t12.overrun); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0, cyc = 0;
        logic prev_busy;
        b_d1.i_in = 16'sd1000;
        while (pulses < 7 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (b_d1.out_valid) pulses++;
        end
        n_vec++; if (b_d1.i_out !== 16'sd750) begin n_err++; $display("FAIL pre_reset_i: got %0d expected 750", b_d1.i_out); end
        cyc = 0; prev_busy = b_d1.busy;
        while (!(b_d1.busy && !prev_busy) && cyc < 60) begin
            prev_busy = b_d1.busy; @(negedge clk); cyc++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; b_d1.i_in = 16'sd0;
        #1;
        n_vec++; if (b_d1.i_out !== 16'sd0) begin n_err++; $display("FAIL midreset_i: got %0d expected 0", b_d1.i_out); end
        n_vec++; if (b_d1.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", b_d1.busy); end
        n_vec++; if (b_def.i_out !== 16'sd0) begin n_err++; $display("FAIL midreset_def_i: got %0d expected 0", b_def.i_out); end
        n_vec++; if (b_def.q_out !== 16'sd0) begin n_err++; $display("FAIL midreset_def_q: got %0d expected 0", b_def.q_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        while (!b_d1.out_valid && cyc < 60) begin @(negedge clk); cyc++; end
        n_vec++; if (b_d1.out_valid !== 1'b1) begin n_err++; $display("FAIL postreset_timeout: got valid %b expected 1", b_d1.out_valid); end
        n_vec++; if (b_d1.i_out !== 16'sd0) begin n_err++; $display("FAIL postreset_i: got %0d expected 0", b_d1.i_out); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_start_drop();
        test_impulse();
        test_saturation();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
